axil_protocol_monitor: RTL and testbench
========================================

Name: axil_protocol_monitor

Overview:
Synthesizable, parametrised AXI4-Lite protocol monitor for the five channels of one master/slave link. It succeeds the assertion-only per-channel checkers with RTL that exposes violations as registered hardware outputs. It adds per-channel handshake-stall timeouts, payload-stability checks, outstanding-transaction tracking with overflow and orphan-response detection, sticky/first-error capture and a saturating error counter. It is usable in silicon debug as well as in simulation.

Parameters:
C_AXI_DATA_WIDTH, 32, data bus width (WSTRB width = C_AXI_DATA_WIDTH/8)
C_AXI_ADDR_WIDTH, 8, address bus width
MAX_WAIT, 5, max consecutive stalled cycles per channel; 0 disables timeout checks
MAX_OUTSTANDING, 4, max accepted-but-unanswered reads, and separately writes
ERR_CNT_W, 16, width of error counter

Ports:
AXI_ACLK in 1 clock
AXI_ARESETN in 1 asynchronous active-low reset
AXI_ARADDR, AXI_ARPROT[2:0], AXI_ARVALID, AXI_ARREADY in, read address channel
AXI_RDATA, AXI_RRESP[1:0], AXI_RVALID, AXI_RREADY in, read data channel
AXI_AWADDR, AXI_AWPROT[2:0], AXI_AWVALID, AXI_AWREADY in, write address channel
AXI_WDATA, AXI_WSTRB, AXI_WVALID, AXI_WREADY in, write data channel
AXI_BRESP[1:0], AXI_BVALID, AXI_BREADY in, write response channel
err_clr in 1 synchronous clear of error capture state
err_sticky out NUM_ERR accumulated error bits
err_pulse out 1 high one cycle when any error bit is newly detected
first_err_valid out 1 first_err_code holds a captured error
first_err_code out 4 index of lowest-numbered error in first erroring cycle
err_count out ERR_CNT_W detection cycles, saturating
rd_outstanding out $clog2(MAX_OUTSTANDING+1) accepted reads without R
wr_outstanding out $clog2(MAX_OUTSTANDING+1) completed AW+W pairs without B

Behaviour:
- Reset: all outputs, counters and history are 0.
- Checks are sampled on each rising edge. Errors are registered, so an error is visible on the edge after the offending cycle.
- Handshake on a channel = VALID & READY.
- Stall = VALID & !READY.
- Error indices, NUM_ERR=13:
  - 0-4 STABLE_{AR,R,AW,W,B}
  - 5-9 TIMEOUT_{AR,R,AW,W,B}
  - 10 R_UNEXPECTED
  - 11 B_UNEXPECTED
  - 12 OUTSTANDING_OVF
- Stability:
  - If the previous cycle was a stall, VALID must be 1 and the payload must equal the previous cycle's payload.
  - Payload per channel: AR = ADDR+PROT; R = DATA+RESP; AW = ADDR+PROT; W = DATA+STRB; B = RESP.
  - A VALID drop or a payload change sets STABLE_x.
- Timeout:
  - Stall counter increments per stall cycle, clears on any non-stall cycle, saturates at MAX_WAIT.
  - A stall sampled while the counter == MAX_WAIT sets TIMEOUT_x. It re-fires every further stalled cycle.
- Read tracking:
  - rd_outstanding is incremented by an AR handshake and decremented by an R handshake; simultaneous events give a net change of 0.
  - An R handshake with rd_outstanding==0 sets R_UNEXPECTED and leaves the count at 0.
- Write tracking:
  - Internal aw_cnt and w_cnt are each incremented by their own handshake. Both are decremented by a B handshake.
  - wr_outstanding = min(aw_cnt, w_cnt).
  - A B handshake with aw_cnt==0 or w_cnt==0 sets B_UNEXPECTED; neither counter changes.
- Overflow:
  - An increment into a counter already at MAX_OUTSTANDING, with no simultaneous decrement, sets OUTSTANDING_OVF and holds the count.
- Capture:
  - err_sticky |= new errors.
  - err_pulse = |new.
  - err_count += 1 per cycle with |new, saturating at all-ones.
  - first_err_code and first_err_valid load only while first_err_valid==0.
- err_clr:
  - Clears err_sticky, first_err_*, err_count and err_pulse on the next edge. Traffic counters are not cleared.
  - If err_clr and a new error occur together, the new error wins: it is captured after the clear.
- Reset mid-transaction: all counters go to 0. Post-reset R/B handshakes for pre-reset requests flag *_UNEXPECTED, which is intended.

Decomposition:
- Package axil_mon_pkg:
  - err_idx_e enum for indices 0-12
  - NUM_ERR=13
  - localparams for channel count and PROT/RESP widths
- Sub-module axil_chan_watch:
  - Parameters PW (payload width) and MAX_WAIT.
  - Ports valid, ready, payload; outputs stable_err, timeout_err.
  - Instantiated five times. The top level holds the outstanding counters and error capture.

Test Plan:
- Clean traffic, MAX_WAIT=5: 3 back-to-back writes and reads, READY within 2 cycles → err_sticky=0, err_count=0, both outstanding counts return to 0.
- ARVALID high with ARREADY low for 7 cycles → TIMEOUT_AR on the edge after the 6th stall cycle, err_count=2, first_err_code=5.
- AWADDR changes 0x10→0x14 while stalled → STABLE_AW set, err_pulse for exactly 1 cycle.
- R handshake with no prior AR → R_UNEXPECTED; rd_outstanding stays 0.
- W handshake only, then B handshake → B_UNEXPECTED; w_cnt holds at 1 and wr_outstanding stays 0.
- 5 AR handshakes, RREADY never asserted, MAX_OUTSTANDING=4 → OUTSTANDING_OVF and rd_outstanding=4. Then assert err_clr → all error outputs 0 while rd_outstanding stays 4. Then assert AXI_ARESETN low mid-burst → every output is 0 immediately.

Source files
------------

// File: rtl/axil_protocol_monitor_pkg.sv
// Shared definitions for the AXI4-Lite protocol monitor: error indices,
// channel/field widths and the first-error priority encoder.
package axil_mon_pkg;

    localparam int unsigned NUM_ERR  = 13;
    localparam int unsigned NUM_CHAN = 5;
    localparam int unsigned PROT_W   = 3;
    localparam int unsigned RESP_W   = 2;
    localparam int unsigned CODE_W   = 4;

    typedef enum logic [CODE_W-1:0] {
        ErrStableAr    = 4'd0,
        ErrStableR     = 4'd1,
        ErrStableAw    = 4'd2,
        ErrStableW     = 4'd3,
        ErrStableB     = 4'd4,
        ErrTimeoutAr   = 4'd5,
        ErrTimeoutR    = 4'd6,
        ErrTimeoutAw   = 4'd7,
        ErrTimeoutW    = 4'd8,
        ErrTimeoutB    = 4'd9,
        ErrRUnexpected = 4'd10,
        ErrBUnexpected = 4'd11,
        ErrOutstOvf    = 4'd12
    } err_idx_e;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [CODE_W-1:0] first_err_idx(input logic [NUM_ERR-1:0] errs);
        first_err_idx = '0;
        for (int i = NUM_ERR - 1; i >= 0; i--) begin
            if (errs[i]) first_err_idx = CODE_W'(i);
        end
    endfunction

endpackage

// File: rtl/axil_protocol_monitor_if.sv
// AXI4-Lite link bundle. The monitor attaches through the passive modport.
interface axil_protocol_monitor_if #(
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_AXI_ADDR_WIDTH = 8
);
    import axil_mon_pkg::*;

    logic [C_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [PROT_W-1:0]             arprot;
    logic                          arvalid;
    logic                          arready;
    logic [C_AXI_DATA_WIDTH-1:0]   rdata;
    logic [RESP_W-1:0]             rresp;
    logic                          rvalid;
    logic                          rready;
    logic [C_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [PROT_W-1:0]             awprot;
    logic                          awvalid;
    logic                          awready;
    logic [C_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                          wvalid;
    logic                          wready;
    logic [RESP_W-1:0]             bresp;
    logic                          bvalid;
    logic                          bready;

    modport master (
        output araddr, arprot, arvalid, rready, awaddr, awprot, awvalid,
               wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arprot, arvalid, rready, awaddr, awprot, awvalid,
               wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport monitor (
        input araddr, arprot, arvalid, arready, rdata, rresp, rvalid, rready,
              awaddr, awprot, awvalid, awready, wdata, wstrb, wvalid, wready,
              bresp, bvalid, bready
    );

endinterface

// File: rtl/axil_protocol_monitor_chan_watch.sv
// Single-channel watcher: flags VALID drops / payload changes after a stall,
// and stalls that persist past MAX_WAIT cycles. Error outputs describe the
// current cycle; the top level registers them.
module axil_chan_watch #(
    parameter int unsigned PW       = 8,
    parameter int unsigned MAX_WAIT = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    input  logic          i_ready,
    input  logic [PW-1:0] i_payload,
    output logic          o_stable_err,
    output logic          o_timeout_err
);

    localparam int unsigned CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic          w_stall;
    logic          r_prev_stall;
    logic [PW-1:0] r_prev_payload;
    logic [CW-1:0] r_stall_cnt;

    assign w_stall = i_valid & ~i_ready;

    // Previous-cycle history and saturating stall counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_stall   <= 1'b0;
            r_prev_payload <= '0;
            r_stall_cnt    <= '0;
        end else begin
            r_prev_stall   <= w_stall;
            r_prev_payload <= i_payload;
            if (!w_stall) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != CW'(MAX_WAIT)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign o_stable_err  = r_prev_stall & (~i_valid | (i_payload != r_prev_payload));
    // With MAX_WAIT == 0 the counter never leaves 0, so the enable term is what disables it.
    assign o_timeout_err = (MAX_WAIT != 0) && w_stall && (r_stall_cnt == CW'(MAX_WAIT));

endmodule

// File: rtl/axil_protocol_monitor.sv
// AXI4-Lite protocol monitor: five channel watchers, outstanding-transaction
// tracking and sticky / first-error / counted error capture.
module axil_protocol_monitor
    import axil_mon_pkg::*;
#(
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_AXI_ADDR_WIDTH = 8,
    parameter int unsigned MAX_WAIT         = 5,
    parameter int unsigned MAX_OUTSTANDING  = 4,
    parameter int unsigned ERR_CNT_W        = 16,
    localparam int unsigned OW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  i_axi_aclk,
    input  logic                  i_axi_aresetn,
    axil_protocol_monitor_if.monitor i_axi,
    input  logic                  i_err_clr,
    output logic [NUM_ERR-1:0]    o_err_sticky,
    output logic                  o_err_pulse,
    output logic                  o_first_err_valid,
    output logic [CODE_W-1:0]     o_first_err_code,
    output logic [ERR_CNT_W-1:0]  o_err_count,
    output logic [OW-1:0]         o_rd_outstanding,
    output logic [OW-1:0]         o_wr_outstanding
);

    localparam int unsigned AW_PW = C_AXI_ADDR_WIDTH + PROT_W;
    localparam int unsigned R_PW  = C_AXI_DATA_WIDTH + RESP_W;
    localparam int unsigned W_PW  = C_AXI_DATA_WIDTH + C_AXI_DATA_WIDTH / 8;
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

    logic [NUM_CHAN-1:0] w_stable, w_timeout;
    logic [NUM_ERR-1:0]  w_new;
    logic                w_any;
    logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
    logic w_rd_dec, w_b_ok, w_rd_ovf, w_aw_ovf, w_w_ovf;
    logic [OW-1:0] r_rd_cnt, r_aw_cnt, r_w_cnt;
    logic [OW-1:0] w_rd_cnt_nxt, w_aw_cnt_nxt, w_w_cnt_nxt;

    assign w_ar_hs = i_axi.arvalid & i_axi.arready;
    assign w_r_hs  = i_axi.rvalid  & i_axi.rready;
    assign w_aw_hs = i_axi.awvalid & i_axi.awready;
    assign w_w_hs  = i_axi.wvalid  & i_axi.wready;
    assign w_b_hs  = i_axi.bvalid  & i_axi.bready;

    axil_chan_watch #(.PW(AW_PW), .MAX_WAIT(MAX_WAIT)) u_ar (
        .i_clk(i_axi_aclk), .i_rst_n(i_axi_aresetn),
        .i_valid(i_axi.arvalid), .i_ready(i_axi.arready),
        .i_payload({i_axi.araddr, i_axi.arprot}),
        .o_stable_err(w_stable[0]), .o_timeout_err(w_timeout[0])
    );
    axil_chan_watch #(.PW(R_PW), .MAX_WAIT(MAX_WAIT)) u_r (
        .i_clk(i_axi_aclk), .i_rst_n(i_axi_aresetn),
        .i_valid(i_axi.rvalid), .i_ready(i_axi.rready),
        .i_payload({i_axi.rdata, i_axi.rresp}),
        .o_stable_err(w_stable[1]), .o_timeout_err(w_timeout[1])
    );
    axil_chan_watch #(.PW(AW_PW), .MAX_WAIT(MAX_WAIT)) u_aw (
        .i_clk(i_axi_aclk), .i_rst_n(i_axi_aresetn),
        .i_valid(i_axi.awvalid), .i_ready(i_axi.awready),
        .i_payload({i_axi.awaddr, i_axi.awprot}),
        .o_stable_err(w_stable[2]), .o_timeout_err(w_timeout[2])
    );
    axil_chan_watch #(.PW(W_PW), .MAX_WAIT(MAX_WAIT)) u_w (
        .i_clk(i_axi_aclk), .i_rst_n(i_axi_aresetn),
        .i_valid(i_axi.wvalid), .i_ready(i_axi.wready),
        .i_payload({i_axi.wdata, i_axi.wstrb}),
        .o_stable_err(w_stable[3]), .o_timeout_err(w_timeout[3])
    );
    axil_chan_watch #(.PW(RESP_W), .MAX_WAIT(MAX_WAIT)) u_b (
        .i_clk(i_axi_aclk), .i_rst_n(i_axi_aresetn),
        .i_valid(i_axi.bvalid), .i_ready(i_axi.bready),
        .i_payload(i_axi.bresp),
        .o_stable_err(w_stable[4]), .o_timeout_err(w_timeout[4])
    );

    // Next-state of outstanding counters; orphan responses and overflow leave counts untouched.
    always_comb begin
        w_rd_cnt_nxt = r_rd_cnt;
        w_aw_cnt_nxt = r_aw_cnt;
        w_w_cnt_nxt  = r_w_cnt;
        w_rd_ovf     = 1'b0;
        w_aw_ovf     = 1'b0;
        w_w_ovf      = 1'b0;
        w_rd_dec     = w_r_hs && (r_rd_cnt != '0);
        w_b_ok       = w_b_hs && (r_aw_cnt != '0) && (r_w_cnt != '0);

        if (w_ar_hs && !w_rd_dec) begin
            if (r_rd_cnt == MAX_OUT) w_rd_ovf = 1'b1;
            else                     w_rd_cnt_nxt = r_rd_cnt + 1'b1;
        end else if (!w_ar_hs && w_rd_dec) begin
            w_rd_cnt_nxt = r_rd_cnt - 1'b1;
        end

        if (w_aw_hs && !w_b_ok) begin
            if (r_aw_cnt == MAX_OUT) w_aw_ovf = 1'b1;
            else                     w_aw_cnt_nxt = r_aw_cnt + 1'b1;
        end else if (!w_aw_hs && w_b_ok) begin
            w_aw_cnt_nxt = r_aw_cnt - 1'b1;
        end

        if (w_w_hs && !w_b_ok) begin
            if (r_w_cnt == MAX_OUT) w_w_ovf = 1'b1;
            else                    w_w_cnt_nxt = r_w_cnt + 1'b1;
        end else if (!w_w_hs && w_b_ok) begin
            w_w_cnt_nxt = r_w_cnt - 1'b1;
        end
    end

    // Gather this cycle's violations into the error-index vector.
    always_comb begin
        w_new                 = '0;
        w_new[ErrStableAr]    = w_stable[0];
        w_new[ErrStableR]     = w_stable[1];
        w_new[ErrStableAw]    = w_stable[2];
        w_new[ErrStableW]     = w_stable[3];
        w_new[ErrStableB]     = w_stable[4];
        w_new[ErrTimeoutAr]   = w_timeout[0];
        w_new[ErrTimeoutR]    = w_timeout[1];
        w_new[ErrTimeoutAw]   = w_timeout[2];
        w_new[ErrTimeoutW]    = w_timeout[3];
        w_new[ErrTimeoutB]    = w_timeout[4];
        w_new[ErrRUnexpected] = w_r_hs && (r_rd_cnt == '0);
        w_new[ErrBUnexpected] = w_b_hs && !w_b_ok;
        w_new[ErrOutstOvf]    = w_rd_ovf | w_aw_ovf | w_w_ovf;
    end

    assign w_any = |w_new;

    // Traffic counters; err_clr deliberately does not touch them.
    always_ff @(posedge i_axi_aclk or negedge i_axi_aresetn) begin
        if (!i_axi_aresetn) begin
            r_rd_cnt <= '0;
            r_aw_cnt <= '0;
            r_w_cnt  <= '0;
        end else begin
            r_rd_cnt <= w_rd_cnt_nxt;
            r_aw_cnt <= w_aw_cnt_nxt;
            r_w_cnt  <= w_w_cnt_nxt;
        end
    end

    // Error capture; on err_clr the state restarts from this cycle's errors so they are not lost.
    always_ff @(posedge i_axi_aclk or negedge i_axi_aresetn) begin
        if (!i_axi_aresetn) begin
            o_err_sticky      <= '0;
            o_err_pulse       <= 1'b0;
            o_first_err_valid <= 1'b0;
            o_first_err_code  <= '0;
            o_err_count       <= '0;
        end else begin
            o_err_pulse <= w_any;
            if (i_err_clr) begin
                o_err_sticky      <= w_new;
                o_first_err_valid <= w_any;
                o_first_err_code  <= first_err_idx(w_new);
                o_err_count       <= ERR_CNT_W'(w_any);
            end else begin
                o_err_sticky <= o_err_sticky | w_new;
                if (!o_first_err_valid && w_any) begin
                    o_first_err_valid <= 1'b1;
                    o_first_err_code  <= first_err_idx(w_new);
                end
                if (w_any && (o_err_count != '1)) o_err_count <= o_err_count + 1'b1;
            end
        end
    end

    assign o_rd_outstanding = r_rd_cnt;
    assign o_wr_outstanding = (r_aw_cnt < r_w_cnt) ? r_aw_cnt : r_w_cnt;

endmodule

// File: tb/tb_axil_protocol_monitor.sv
// Directed bench for axil_protocol_monitor (default parameters).
module tb_axil_protocol_monitor;

    logic        clk;
    logic        rst_n;
    logic        err_clr;
    logic [12:0] err_sticky;
    logic        err_pulse;
    logic        first_err_valid;
    logic [3:0]  first_err_code;
    logic [15:0] err_count;
    logic [2:0]  rd_out;
    logic [2:0]  wr_out;

    int n_checks = 0;
    int n_errors = 0;

    axil_protocol_monitor_if #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(8)) axi ();

    axil_protocol_monitor #(
        .C_AXI_DATA_WIDTH(32),
        .C_AXI_ADDR_WIDTH(8),
        .MAX_WAIT(5),
        .MAX_OUTSTANDING(4),
        .ERR_CNT_W(16)
    ) dut (
        .i_axi_aclk(clk),
        .i_axi_aresetn(rst_n),
        .i_axi(axi),
        .i_err_clr(err_clr),
        .o_err_sticky(err_sticky),
        .o_err_pulse(err_pulse),
        .o_first_err_valid(first_err_valid),
        .o_first_err_code(first_err_code),
        .o_err_count(err_count),
        .o_rd_outstanding(rd_out),
        .o_wr_outstanding(wr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, leaving time 1 unit past the last edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_bus();
        axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.arready = 1'b0;
        axi.rdata  = '0; axi.rresp  = '0; axi.rvalid  = 1'b0; axi.rready  = 1'b0;
        axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0; axi.awready = 1'b0;
        axi.wdata  = '0; axi.wstrb  = '0; axi.wvalid  = 1'b0; axi.wready  = 1'b0;
        axi.bresp  = '0; axi.bvalid = 1'b0; axi.bready = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        err_clr = 1'b0;
        idle_bus();
        step(2);
        check("rst_sticky", 32'(err_sticky), 32'h0);
        check("rst_pulse", 32'(err_pulse), 32'h0);
        check("rst_first_valid", 32'(first_err_valid), 32'h0);
        check("rst_count", 32'(err_count), 32'h0);
        check("rst_rd_out", 32'(rd_out), 32'h0);
        check("rst_wr_out", 32'(wr_out), 32'h0);
        rst_n = 1'b1;
        step(1);

        // Clean traffic: three writes then three reads, READY one cycle late.
        for (int i = 0; i < 3; i++) begin
            axi.awvalid = 1'b1; axi.awaddr = 8'(8'h20 + 4 * i);
            axi.wvalid  = 1'b1; axi.wdata  = 32'hA000_0000 + i; axi.wstrb = 4'hF;
            step(1);
            axi.awready = 1'b1; axi.wready = 1'b1;
            step(1);
            check("clean_wr_out_1", 32'(wr_out), 32'h1);
            axi.awvalid = 1'b0; axi.awready = 1'b0; axi.wvalid = 1'b0; axi.wready = 1'b0;
            axi.bvalid = 1'b1; axi.bready = 1'b1;
            step(1);
            axi.bvalid = 1'b0; axi.bready = 1'b0;
        end
        check("clean_wr_out_0", 32'(wr_out), 32'h0);
        for (int i = 0; i < 3; i++) begin
            axi.arvalid = 1'b1; axi.araddr = 8'(8'h30 + 4 * i);
            step(1);
            axi.arready = 1'b1;
            step(1);
            check("clean_rd_out_1", 32'(rd_out), 32'h1);
            axi.arvalid = 1'b0; axi.arready = 1'b0;
            axi.rvalid = 1'b1; axi.rready = 1'b1; axi.rdata = 32'h5A5A_0000 + i;
            step(1);
            axi.rvalid = 1'b0; axi.rready = 1'b0;
        end
        check("clean_rd_out_0", 32'(rd_out), 32'h0);
        check("clean_sticky", 32'(err_sticky), 32'h0);
        check("clean_count", 32'(err_count), 32'h0);

        // AR stalled 7 cycles: timeout fires on stalls 6 and 7.
        axi.arvalid = 1'b1; axi.araddr = 8'h40;
        step(5);
        check("to_ar_quiet", 32'(err_sticky), 32'h0);
        step(1);
        check("to_ar_sticky", 32'(err_sticky), 32'h0020);
        check("to_ar_pulse", 32'(err_pulse), 32'h1);
        check("to_ar_count1", 32'(err_count), 32'h1);
        check("to_ar_first_valid", 32'(first_err_valid), 32'h1);
        check("to_ar_first_code", 32'(first_err_code), 32'h5);
        step(1);
        check("to_ar_count2", 32'(err_count), 32'h2);
        axi.arready = 1'b1;
        step(1);
        axi.arvalid = 1'b0; axi.arready = 1'b0;
        check("to_ar_pulse_off", 32'(err_pulse), 32'h0);
        check("to_ar_count_hold", 32'(err_count), 32'h2);
        check("to_ar_rd_out", 32'(rd_out), 32'h1);
        axi.rvalid = 1'b1; axi.rready = 1'b1;
        step(1);
        axi.rvalid = 1'b0; axi.rready = 1'b0;
        pulse_clr();
        check("clr_sticky", 32'(err_sticky), 32'h0);
        check("clr_count", 32'(err_count), 32'h0);
        check("clr_rd_out", 32'(rd_out), 32'h0);

        // AWADDR changes while stalled.
        axi.awvalid = 1'b1; axi.awaddr = 8'h10;
        step(1);
        axi.awaddr = 8'h14;
        step(1);
        check("st_aw_sticky", 32'(err_sticky), 32'h0004);
        check("st_aw_pulse", 32'(err_pulse), 32'h1);
        check("st_aw_code", 32'(first_err_code), 32'h2);
        step(1);
        check("st_aw_pulse_off", 32'(err_pulse), 32'h0);
        check("st_aw_count", 32'(err_count), 32'h1);
        axi.awready = 1'b1;
        step(1);
        axi.awvalid = 1'b0; axi.awready = 1'b0;
        check("st_aw_wr_out0", 32'(wr_out), 32'h0);
        axi.wvalid = 1'b1; axi.wready = 1'b1;
        step(1);
        axi.wvalid = 1'b0; axi.wready = 1'b0;
        check("st_aw_wr_out1", 32'(wr_out), 32'h1);
        axi.bvalid = 1'b1; axi.bready = 1'b1;
        step(1);
        axi.bvalid = 1'b0; axi.bready = 1'b0;
        check("st_aw_wr_out_done", 32'(wr_out), 32'h0);
        pulse_clr();

        // R with nothing outstanding.
        axi.rvalid = 1'b1; axi.rready = 1'b1;
        step(1);
        axi.rvalid = 1'b0; axi.rready = 1'b0;
        check("r_unexp_sticky", 32'(err_sticky), 32'h0400);
        check("r_unexp_rd_out", 32'(rd_out), 32'h0);
        check("r_unexp_code", 32'(first_err_code), 32'hA);
        pulse_clr();

        // W only, then B: orphan B; the held W is later paired with an AW.
        axi.wvalid = 1'b1; axi.wready = 1'b1;
        step(1);
        axi.wvalid = 1'b0; axi.wready = 1'b0;
        axi.bvalid = 1'b1; axi.bready = 1'b1;
        step(1);
        axi.bvalid = 1'b0; axi.bready = 1'b0;
        check("b_unexp_sticky", 32'(err_sticky), 32'h0800);
        check("b_unexp_wr_out", 32'(wr_out), 32'h0);
        axi.awvalid = 1'b1; axi.awready = 1'b1;
        step(1);
        axi.awvalid = 1'b0; axi.awready = 1'b0;
        check("b_unexp_w_held", 32'(wr_out), 32'h1);
        axi.bvalid = 1'b1; axi.bready = 1'b1;
        step(1);
        axi.bvalid = 1'b0; axi.bready = 1'b0;
        check("b_unexp_wr_done", 32'(wr_out), 32'h0);
        check("b_unexp_sticky_hold", 32'(err_sticky), 32'h0800);
        pulse_clr();

        // Five back-to-back AR handshakes with MAX_OUTSTANDING = 4.
        axi.arvalid = 1'b1; axi.arready = 1'b1; axi.araddr = 8'h80;
        step(4);
        check("ovf_rd_out4", 32'(rd_out), 32'h4);
        check("ovf_quiet", 32'(err_sticky), 32'h0);
        step(1);
        check("ovf_sticky", 32'(err_sticky), 32'h1000);
        check("ovf_rd_hold", 32'(rd_out), 32'h4);
        check("ovf_code", 32'(first_err_code), 32'hC);
        axi.arvalid = 1'b0; axi.arready = 1'b0;
        pulse_clr();
        check("ovf_clr_sticky", 32'(err_sticky), 32'h0);
        check("ovf_clr_pulse", 32'(err_pulse), 32'h0);
        check("ovf_clr_count", 32'(err_count), 32'h0);
        check("ovf_clr_first_valid", 32'(first_err_valid), 32'h0);
        check("ovf_clr_rd_out", 32'(rd_out), 32'h4);

        // Reset asserted between edges in the middle of a burst.
        axi.arvalid = 1'b1; axi.arready = 1'b1;
        step(1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_sticky", 32'(err_sticky), 32'h0);
        check("arst_pulse", 32'(err_pulse), 32'h0);
        check("arst_first_valid", 32'(first_err_valid), 32'h0);
        check("arst_first_code", 32'(first_err_code), 32'h0);
        check("arst_count", 32'(err_count), 32'h0);
        check("arst_rd_out", 32'(rd_out), 32'h0);
        check("arst_wr_out", 32'(wr_out), 32'h0);
        idle_bus();
        step(2);
        rst_n = 1'b1;
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
